// File: rtl/m_ucode_store.sv
// Microcode control store: NSLICES x 16-bit words, 2**AW deep, 1-cycle registered read.
// A byte-stream loader can rewrite the whole store while the core is stalled via ucode_busy.
module m_ucode_store #(
    parameter int UCODETYPE = 0,
    parameter int NSLICES   = 3,
    parameter int AW        = 8,
    parameter int USE_EBR   = 1,
    parameter int LOADABLE  = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [AW-1:0]           minx,
    input  logic                    progress_ucode,
    output logic [16*NSLICES-1:0]   d,
    input  logic                    ld_start,
    input  logic                    ld_valid,
    input  logic [7:0]              ld_data,
    output logic                    ld_ready,
    output logic                    ucode_busy,
    output logic                    ld_done,
    output logic [16*NSLICES-1:0]   ld_csum
);

    localparam int W      = 16 * NSLICES;
    localparam int DEPTH  = 1 << AW;
    localparam int NBYTES = 2 * NSLICES;
    localparam int BCW    = $clog2(NBYTES);

    typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_WRITE, S_DONE} state_t;
    typedef logic [DEPTH-1:0][15:0]  slice_img_t;
    typedef logic [DEPTH-1:0][W-1:0] word_img_t;

    // Power-up image: UCODETYPE 0 is the generated microcode pattern, anything else is blank.
    function automatic logic [15:0] f_init_half(input int s, input int a);
        if (UCODETYPE != 0) return 16'h0000;
        return 16'((((s + 1) % 16) << 12) ^ (a * 7));
    endfunction

    function automatic slice_img_t f_slice_img(input int s);
        slice_img_t img;
        for (int a = 0; a < DEPTH; a++) img[a] = f_init_half(s, a);
        return img;
    endfunction

    function automatic word_img_t f_word_img();
        word_img_t img;
        for (int a = 0; a < DEPTH; a++)
            for (int s = 0; s < NSLICES; s++) img[a][16*s +: 16] = f_init_half(s, a);
        return img;
    endfunction

    state_t          r_state;
    state_t          w_state_nx;
    logic [AW-1:0]   r_addr;
    logic [BCW-1:0]  r_bcnt;
    logic [W-1:0]    r_buf;
    logic [W-1:0]    r_csum;
    logic [W-1:0]    r_d;
    logic [W-1:0]    w_rd;
    logic            w_start;
    logic            w_accept;
    logic            w_last_byte;
    logic            w_we;

    assign w_start     = (r_state == S_IDLE) && ld_start && (LOADABLE != 0);
    assign w_accept    = (r_state == S_COLLECT) && ld_valid;
    assign w_last_byte = (r_bcnt == BCW'(NBYTES - 1));
    assign w_we        = (r_state == S_WRITE);

    // Storage: per-slice 256x16 arrays (block RAM shape) or one wide word array; same timing.
    if (USE_EBR != 0) begin : g_ebr
        for (genvar s = 0; s < NSLICES; s++) begin : g_slice
            slice_img_t r_slice = f_slice_img(s);

            // Loader write port for this slice; never active while reads are enabled.
            always_ff @(posedge clk) begin
                if (w_we) r_slice[r_addr] <= r_buf[16*s +: 16];
            end

            assign w_rd[16*s +: 16] = r_slice[minx];
        end
    end else begin : g_lut
        word_img_t r_mem = f_word_img();

        // Loader write port for the whole word.
        always_ff @(posedge clk) begin
            if (w_we) r_mem[r_addr] <= r_buf;
        end

        assign w_rd = r_mem[minx];
    end

    // Read register: follows minx only when the core advances and the loader is idle.
    always_ff @(posedge clk) begin
        if (rst)                                 r_d <= '0;
        else if (progress_ucode && !ucode_busy)  r_d <= w_rd;
    end

    // Loader state register.
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nx;
    end

    // Loader next state and status outputs.
    always_comb begin
        w_state_nx = r_state;
        ld_ready   = 1'b0;
        ucode_busy = 1'b1;
        ld_done    = 1'b0;
        case (r_state)
            S_IDLE: begin
                ucode_busy = 1'b0;
                if (w_start) w_state_nx = S_COLLECT;
            end
            S_COLLECT: begin
                ld_ready = 1'b1;
                if (w_accept && w_last_byte) w_state_nx = S_WRITE;
            end
            S_WRITE: begin
                w_state_nx = (r_addr == '1) ? S_DONE : S_COLLECT;
            end
            S_DONE: begin
                ld_done    = 1'b1;
                w_state_nx = S_IDLE;
            end
            default: w_state_nx = S_IDLE;
        endcase
    end

    // Running checksum of written words, cleared at the start of each load.
    always_ff @(posedge clk) begin
        if (rst)          r_csum <= '0;
        else if (w_start) r_csum <= '0;
        else if (w_we)    r_csum <= r_csum ^ r_buf;
    end

    // Loader datapath: word assembly (little-endian bytes) and write address.
    always_ff @(posedge clk) begin
        if (w_start) begin
            r_addr <= '0;
            r_bcnt <= '0;
        end
        if (w_accept) begin
            r_buf[{r_bcnt, 3'b000} +: 8] <= ld_data;
            r_bcnt <= w_last_byte ? '0 : r_bcnt + 1'b1;
        end
        if (w_we && (r_addr != '1)) r_addr <= r_addr + 1'b1;
    end

    assign d       = r_d;
    assign ld_csum = r_csum;

endmodule

// File: tb/tb_m_ucode_store.sv
// Bench for m_ucode_store: directed loads/reads checked every cycle against a behavioural model.
module tb_m_ucode_store;

    localparam int W     = 48;
    localparam int DEPTH = 256;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [7:0]    minx = '0;
    logic          progress_ucode = 1'b0;
    logic          ld_start = 1'b0;
    logic          ld_valid = 1'b0;
    logic [7:0]    ld_data = '0;
    logic [W-1:0]  d;
    logic          ld_ready;
    logic          ucode_busy;
    logic          ld_done;
    logic [W-1:0]  ld_csum;

    m_ucode_store dut (
        .clk(clk), .rst(rst), .minx(minx), .progress_ucode(progress_ucode), .d(d),
        .ld_start(ld_start), .ld_valid(ld_valid), .ld_data(ld_data), .ld_ready(ld_ready),
        .ucode_busy(ucode_busy), .ld_done(ld_done), .ld_csum(ld_csum)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int done_cnt = 0;
    bit chk_en = 1'b0;

    // Model state: contents, read register, and load progress in bytes.
    logic [W-1:0] exp_mem [DEPTH];
    logic [W-1:0] m_d = '0;
    logic [W-1:0] m_csum = '0;
    logic [W-1:0] m_buf = '0;
    bit           m_act = 1'b0;
    bit           m_wr = 1'b0;
    bit           m_dn = 1'b0;
    int           m_taken = 0;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] pat_word(input int k, input int p);
        if (p == 0) return {16'hA5A5, 16'(k), 16'(k)};
        return {16'h5A5A, 16'hFF00 ^ 16'(k), 16'(k)};
    endfunction

    // Model: a load takes 6 accepted bytes per word, then one write cycle, then one done cycle.
    always @(posedge clk) begin
        if (rst) begin
            m_d = '0; m_act = 0; m_wr = 0; m_dn = 0; m_csum = '0;
        end else begin
            if (progress_ucode && !m_act) m_d = exp_mem[minx];
            if (!m_act) begin
                if (ld_start) begin m_act = 1; m_taken = 0; m_csum = '0; end
            end else if (m_dn) begin
                m_act = 0; m_dn = 0;
            end else if (m_wr) begin
                m_wr = 0;
                exp_mem[(m_taken / 6) - 1] = m_buf;
                m_csum = m_csum ^ m_buf;
                if (m_taken == 6 * DEPTH) m_dn = 1;
            end else if (ld_valid) begin
                m_buf[8 * (m_taken % 6) +: 8] = ld_data;
                m_taken++;
                if (m_taken % 6 == 0) m_wr = 1;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("d", d, m_d);
            chk("busy", W'(ucode_busy), W'(m_act));
            chk("ready", W'(ld_ready), W'(m_act && !m_wr && !m_dn));
            chk("done", W'(ld_done), W'(m_dn));
            chk("csum", ld_csum, m_csum);
            if (ld_done) done_cnt++;
        end
    end

    task automatic start_load();
        @(negedge clk); ld_start = 1'b1;
        @(negedge clk); ld_start = 1'b0;
    endtask

    task automatic feed(input int nbytes, input int p, input bit gaps, input bit poke);
        int i = 0;
        int guard = 0;
        logic [W-1:0] w;
        while (i < nbytes && guard < 40000) begin
            @(negedge clk);
            guard++;
            w = pat_word(i / 6, p);
            ld_data  = w[8 * (i % 6) +: 8];
            ld_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            if (poke) begin
                ld_start       = 1'($urandom_range(0, 7) == 0);
                progress_ucode = 1'b1;
                minx           = 8'($urandom_range(0, 255));
            end
            if (ld_valid && ld_ready) i++;
        end
        if (i < nbytes) chk("feed_timeout", W'(i), W'(nbytes));
        @(negedge clk);
        ld_valid = 1'b0; ld_start = 1'b0; progress_ucode = 1'b0;
    endtask

    task automatic wait_idle();
        int guard = 0;
        while (ucode_busy && guard < 50) begin @(negedge clk); guard++; end
        if (ucode_busy) chk("idle_timeout", W'(ucode_busy), '0);
    endtask

    task automatic read_all();
        @(negedge clk); progress_ucode = 1'b1;
        for (int a = 0; a < DEPTH; a++) begin minx = 8'(a); @(negedge clk); end
        progress_ucode = 1'b0;
    endtask

    task automatic check_lit(input string name, input logic [7:0] addr, input logic [W-1:0] exp);
        @(negedge clk); minx = addr; progress_ucode = 1'b1;
        @(negedge clk); progress_ucode = 1'b0;
        chk(name, d, exp);
    endtask

    initial begin
        for (int a = 0; a < DEPTH; a++)
            exp_mem[a] = {16'h3000 ^ 16'(a * 7), 16'h2000 ^ 16'(a * 7), 16'h1000 ^ 16'(a * 7)};

        // Reset state
        @(negedge clk); chk_en = 1'b1;
        chk("rst_d", d, '0);
        chk("rst_busy", W'(ucode_busy), '0);
        chk("rst_ready", W'(ld_ready), '0);
        chk("rst_done", W'(ld_done), '0);
        chk("rst_csum", ld_csum, '0);
        @(negedge clk); rst = 1'b0;

        // Init image readback
        read_all();
        check_lit("init_42", 8'h42, 48'h31CE_21CE_11CE);
        check_lit("init_ff", 8'hFF, 48'h36F9_26F9_16F9);

        // Hold while progress_ucode is low
        check_lit("init_10", 8'h10, 48'h3070_2070_1070);
        for (int i = 0; i < 5; i++) begin @(negedge clk); minx = 8'(i * 37); end
        @(negedge clk);
        chk("hold_10", d, 48'h3070_2070_1070);
        check_lit("reassert_42", 8'h42, 48'h31CE_21CE_11CE);

        // Full reload, no gaps
        done_cnt = 0;
        start_load();
        feed(6 * DEPTH, 0, 1'b0, 1'b0);
        wait_idle();
        chk("done_cnt3", W'(done_cnt), W'(1));
        chk("csum3", ld_csum, '0);
        read_all();
        check_lit("new_5", 8'h05, 48'hA5A5_0005_0005);

        // Reload with gaps, stray ld_start and reads while busy
        check_lit("pre4_9", 8'h09, 48'hA5A5_0009_0009);
        done_cnt = 0;
        start_load();
        feed(6 * DEPTH, 1, 1'b1, 1'b1);
        chk("busy_hold_d", d, 48'hA5A5_0009_0009);
        wait_idle();
        chk("done_cnt4", W'(done_cnt), W'(1));
        read_all();
        check_lit("reload_7", 8'h07, 48'h5A5A_FF07_0007);

        // Abort after 700 bytes
        start_load();
        feed(700, 0, 1'b0, 1'b0);
        rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        chk("abort_busy", W'(ucode_busy), '0);
        chk("abort_d", d, '0);
        read_all();
        check_lit("abort_115", 8'd115, 48'hA5A5_0073_0073);
        check_lit("abort_116", 8'd116, 48'h5A5A_FF74_0074);

        // ld_start together with rst: reset wins
        @(negedge clk); rst = 1'b1; ld_start = 1'b1;
        @(negedge clk); rst = 1'b0; ld_start = 1'b0;
        chk("rst_wins_busy", W'(ucode_busy), '0);
        @(negedge clk);
        chk("rst_wins_ready", W'(ld_ready), '0);

        repeat (2) @(negedge clk);
        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
